// File: rtl/fetch_buffer_pkg.sv
// Fetch buffer shared constants: default geometry and queue entry sizing.
// Used by the fetch stage and by later handshake stages that reuse the FIFO.
package fetch_buffer_pkg;

  localparam int FB_BUS_WIDTH  = 8;
  localparam int FB_DATA_WIDTH = 16;
  localparam int FB_DEPTH      = 256;

  // Entry is {pc, instruction, err}
  function automatic int entry_w(input int bw, input int dw);
    return bw + dw + 1;
  endfunction

endpackage

// File: rtl/fifo_2entry.sv
// Two-entry FIFO with 1-bit pointers and a 2-bit occupancy count.
// Clear has priority over push and pop.
module fifo_2entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (clear) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rp];
  assign empty = (r_cnt == 2'd0);
  assign full  = (r_cnt == 2'd2);

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage buffer: reads program memory at the counter's pc and queues
// {pc, instruction, err} toward decode; stalls the counter when full.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int BUS_WIDTH  = FB_BUS_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int DEPTH      = FB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_WIDTH-1:0]  pc,
  input  logic                  pc_valid,
  input  logic                  flush,
  input  logic                  we,
  input  logic [BUS_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_WIDTH-1:0]  out_pc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  localparam int ENTRY_W = entry_w(BUS_WIDTH, DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_err;
  logic                  w_wok;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ENTRY_W-1:0]    w_din;
  logic [ENTRY_W-1:0]    w_dout;

  assign w_err   = (32'(pc) >= DEPTH);
  assign w_wok   = we && (32'(waddr) < DEPTH);
  assign w_rdata = w_err ? '0 : r_mem[pc];

  // Read is combinational on the old array, so a same-edge write
  // to the fetched address is seen only by later fetches.
  always_ff @(posedge clk) begin
    if (w_wok) r_mem[waddr] <= wdata;
  end

  assign w_push = pc_valid && !w_full && !flush;
  assign w_pop  = out_valid && out_ready;
  assign w_din  = {pc, w_rdata, w_err};

  fifo_2entry #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(flush),
    .push (w_push),
    .din  (w_din),
    .pop  (w_pop),
    .dout (w_dout),
    .empty(w_empty),
    .full (w_full)
  );

  assign stall     = w_full;
  assign out_valid = !w_empty;
  assign {out_pc, out_data, out_err} = w_dout;

endmodule
